// File: rtl/key_debounce_pkg.sv
// Shared constants and FSM encoding for the push-button debouncer.
package key_pkg;

    localparam int unsigned CNT_W               = 8;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4_000_000;   // 20 ms at 200 MHz
    localparam int unsigned DEF_LONG_CYCLES     = 200_000_000; // 1 s at 200 MHz

    typedef logic [1:0] key_fsm_t;

    localparam key_fsm_t ST_RELEASED    = 2'd0;
    localparam key_fsm_t ST_PRESS_CHK   = 2'd1;
    localparam key_fsm_t ST_PRESSED     = 2'd2;
    localparam key_fsm_t ST_RELEASE_CHK = 2'd3;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pin and debounced key state/event bundle.
interface key_debounce_if;
    import key_pkg::*;

    logic             key_in;
    logic             key_state;
    logic             press_pulse;
    logic             release_pulse;
    logic             long_pulse;
    logic [CNT_W-1:0] press_count;

    modport master (
        output key_in,
        input  key_state, press_pulse, release_pulse, long_pulse, press_count
    );

    modport slave (
        input  key_in,
        output key_state, press_pulse, release_pulse, long_pulse, press_count
    );

endinterface

// File: rtl/key_debounce_sync_2ff.sv
// Single-bit two-stage synchronizer with a configurable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronized, debounced key level plus press/release/long events.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned KEY_ACTIVE_LOW  = 1
) (
    input  logic           sys_clk,
    input  logic           rst,
    key_debounce_if.slave  kif
);

    localparam int unsigned DEB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic        ACT_LOW  = (KEY_ACTIVE_LOW != 0);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_chk
        $error("key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    logic             key_sync;
    logic             key_act;
    key_fsm_t         state, state_nxt;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic             key_state_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             long_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Synchronizer idles at the released pin level so reset never looks like a press.
    sync_2ff #(.RST_VAL(ACT_LOW)) u_sync (
        .clk (sys_clk),
        .rst (rst),
        .d   (kif.key_in),
        .q   (key_sync)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) key_act <= 1'b0;
        else     key_act <= ACT_LOW ? ~key_sync : key_sync;
    end

    // Next-state and event decode
    always_comb begin
        state_nxt     = state;
        deb_cnt_nxt   = deb_cnt;
        key_state_nxt = kif.key_state;
        cnt_nxt       = kif.press_count;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        case (state)
            ST_RELEASED: begin
                if (key_act) begin
                    state_nxt   = ST_PRESS_CHK;
                    deb_cnt_nxt = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!key_act) begin
                    state_nxt = ST_RELEASED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = ST_PRESSED;
                    press_nxt     = 1'b1;
                    key_state_nxt = 1'b1;
                    cnt_nxt       = kif.press_count + CNT_W'(1);
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!key_act) begin
                    state_nxt   = ST_RELEASE_CHK;
                    deb_cnt_nxt = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (key_act) begin
                    state_nxt = ST_PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = ST_RELEASED;
                    release_nxt   = 1'b1;
                    key_state_nxt = 1'b0;
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
            end
        endcase
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              long_fired, long_fired_nxt;

    // Hold timer: saturates, frozen while release is being qualified, one event per press.
    always_comb begin
        hold_cnt_nxt   = hold_cnt;
        long_fired_nxt = long_fired;
        long_nxt       = 1'b0;
        if (press_nxt) begin
            hold_cnt_nxt   = '0;
            long_fired_nxt = 1'b0;
        end else if (state == ST_PRESSED) begin
            if (hold_cnt == HOLD_LAST && !long_fired) begin
                long_nxt       = 1'b1;
                long_fired_nxt = 1'b1;
            end
            if (key_act && hold_cnt != HOLD_LAST) begin
                hold_cnt_nxt = hold_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_fired <= 1'b0;
        end else begin
            hold_cnt   <= hold_cnt_nxt;
            long_fired <= long_fired_nxt;
        end
    end
`else
    always_comb long_nxt = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state             <= ST_RELEASED;
            deb_cnt           <= '0;
            kif.key_state     <= 1'b0;
            kif.press_pulse   <= 1'b0;
            kif.release_pulse <= 1'b0;
            kif.long_pulse    <= 1'b0;
            kif.press_count   <= '0;
        end else begin
            state             <= state_nxt;
            deb_cnt           <= deb_cnt_nxt;
            kif.key_state     <= key_state_nxt;
            kif.press_pulse   <= press_nxt;
            kif.release_pulse <= release_nxt;
            kif.long_pulse    <= long_nxt;
            kif.press_count   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: run-length reference model plus directed latency checks.
// Build with or without KEY_LONG_PRESS_EN.
module tb_key_debounce;

    localparam int unsigned D = 8;
    localparam int unsigned L = 32;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 sys_clk = ~sys_clk;

    key_debounce_if kif();

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .KEY_ACTIVE_LOW  (1)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .kif     (kif)
    );

    int total = 0;
    int bad   = 0;
    int shown = 0;
    bit chk_en = 1'b0;
    int n_press = 0, n_rel = 0, n_long = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (shown < 40) begin
                shown++;
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
            end
        end
    endtask

    // Reference: pin reaches the FSM three samples late; a level opposite to the accepted
    // one must be seen D+1 samples in a row to be accepted.
    bit          m_acc, m_fired;
    int unsigned m_run, m_hold;
    bit [2:0]    m_pipe;
    bit [7:0]    m_cnt;
    bit          e_state, e_press, e_rel, e_long;
    bit [7:0]    e_cnt;

    always @(posedge sys_clk) begin : model
        bit a, acc, fired, p, r, l;
        int unsigned run, hold;
        bit [2:0] pipe;
        bit [7:0] cnt;
        acc = m_acc; fired = m_fired; run = m_run; hold = m_hold; pipe = m_pipe; cnt = m_cnt;
        p = 1'b0; r = 1'b0; l = 1'b0;
        if (rst) begin
            acc = 1'b0; fired = 1'b0; run = 0; hold = 0; pipe = '0; cnt = '0;
        end else begin
            a    = pipe[2];
            pipe = {pipe[1:0], kif.key_in == 1'b0};
            if (LONG_EN && acc && run == 0 && !fired && hold == L - 1) begin
                l = 1'b1;
                fired = 1'b1;
            end
            if (a != acc) begin
                run++;
                if (run == D + 1) begin
                    acc = a;
                    run = 0;
                    if (a) begin
                        p = 1'b1; cnt++; hold = 0; fired = 1'b0;
                    end else begin
                        r = 1'b1;
                    end
                end
            end else begin
                if (acc && run == 0 && hold < L - 1) hold++;
                run = 0;
            end
        end
        m_acc <= acc; m_fired <= fired; m_run <= run; m_hold <= hold; m_pipe <= pipe; m_cnt <= cnt;
        e_state <= acc; e_press <= p; e_rel <= r; e_long <= l; e_cnt <= cnt;
    end

    // Every-cycle comparison against the model, plus event tallies
    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("key_state",     32'(kif.key_state),     32'(e_state));
            check("press_pulse",   32'(kif.press_pulse),   32'(e_press));
            check("release_pulse", 32'(kif.release_pulse), 32'(e_rel));
            check("long_pulse",    32'(kif.long_pulse),    32'(e_long));
            check("press_count",   32'(kif.press_count),   32'(e_cnt));
            if (kif.press_pulse === 1'b1)   n_press++;
            if (kif.release_pulse === 1'b1) n_rel++;
            if (kif.long_pulse === 1'b1)    n_long++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Edges until the selected pulse is seen (0 press, 1 release, 2 long); -1 on timeout.
    task automatic wait_evt(input int which, input int max_cyc, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < max_cyc) begin
            @(posedge sys_clk);
            #1;
            n++;
            case (which)
                0:       hit = kif.press_pulse;
                1:       hit = kif.release_pulse;
                default: hit = kif.long_pulse;
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL wait_evt%0d: no pulse within %0d cycles", which, max_cyc);
            n = -1;
        end
    endtask

    initial begin : stim
        int n, np0, nr0, nl0;
        kif.key_in = 1'b1;
        rst = 1'b1;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check("rst_key_state", 32'(kif.key_state), 0);
        check("rst_count",     32'(kif.press_count), 0);
        rst = 1'b0;
        tick(5);

        // Clean press, held 40 cycles, then clean release
        kif.key_in = 1'b0;
        wait_evt(0, 40, n);
        check("press_latency", 32'(n - 1), 11);
        check("press_state",   32'(kif.key_state), 1);
        check("press_count1",  32'(kif.press_count), 1);
        tick(40 - n);
        kif.key_in = 1'b1;
        wait_evt(1, 40, n);
        check("release_latency", 32'(n - 1), 11);
        check("release_state",   32'(kif.key_state), 0);
        tick(5);

        // Bounce: toggling every 3 cycles is never accepted
        np0 = n_press;
        for (int i = 0; i < 10; i++) begin
            kif.key_in = ~kif.key_in;
            tick(3);
        end
        kif.key_in = 1'b1;
        tick(20);
        check("bounce_presses", 32'(n_press - np0), 0);
        check("bounce_state",   32'(kif.key_state), 0);
        check("bounce_count",   32'(kif.press_count), 1);

        // Release with a 4-cycle glitch back to pressed
        kif.key_in = 1'b0;
        wait_evt(0, 40, n);
        tick(10);
        np0 = n_press;
        nr0 = n_rel;
        kif.key_in = 1'b1;
        tick(5);
        kif.key_in = 1'b0;
        tick(4);
        kif.key_in = 1'b1;
        wait_evt(1, 40, n);
        check("glitch_release_latency", 32'(n - 1), 11);
        tick(15);
        check("glitch_releases", 32'(n_rel - nr0), 1);
        check("glitch_presses",  32'(n_press - np0), 0);

        // Long hold of ~100 cycles
        kif.key_in = 1'b0;
        wait_evt(0, 40, n);
        nl0 = n_long;
`ifdef KEY_LONG_PRESS_EN
        wait_evt(2, 60, n);
        check("long_latency", 32'(n), 32);
        tick(100 - n);
        check("long_once", 32'(n_long - nl0), 1);
`else
        tick(100);
        check("long_none", 32'(n_long - nl0), 0);
`endif
        kif.key_in = 1'b1;
        wait_evt(1, 40, n);
        tick(5);
        check("count_before_wrap", 32'(kif.press_count), 3);

        // 256 clean pairs: counter passes through 0 and returns to its start
        np0 = n_press;
        for (int i = 0; i < 256; i++) begin
            kif.key_in = 1'b0;
            tick($urandom_range(13, 18));
            kif.key_in = 1'b1;
            tick($urandom_range(13, 18));
            if (i == 252) check("wrap_zero", 32'(kif.press_count), 0);
        end
        check("wrap_presses", 32'(n_press - np0), 256);
        check("wrap_count",   32'(kif.press_count), 3);

        // Reset during PRESS_CHK with the key held
        kif.key_in = 1'b0;
        tick(6);
        rst = 1'b1;
        tick(1);
        check("midrst_state",   32'(kif.key_state), 0);
        check("midrst_press",   32'(kif.press_pulse), 0);
        check("midrst_release", 32'(kif.release_pulse), 0);
        check("midrst_long",    32'(kif.long_pulse), 0);
        check("midrst_count",   32'(kif.press_count), 0);
        rst = 1'b0;
        wait_evt(0, 40, n);
        check("midrst_press_latency", 32'(n - 1), 11);
        check("midrst_count1",        32'(kif.press_count), 1);
        kif.key_in = 1'b1;
        tick(20);

        // Random run lengths straddling the debounce threshold
        for (int i = 0; i < 150; i++) begin
            kif.key_in = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 14));
        end
        kif.key_in = 1'b1;
        tick(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side counterpart to the board's LED driver: reads one raw mechanical push-button and produces clean, debounced key state and single-cycle event pulses.
- Clocked by the 200 MHz single-ended system clock, taken after the differential input buffer.
- Consumers are LED/control logic that must never see bounce or metastable levels.

Parameters:
- DEBOUNCE_CYCLES, 4_000_000, cycles a level must be stable before acceptance (20 ms at 200 MHz); must be >= 2.
- LONG_CYCLES, 200_000_000, cycles in PRESSED before long_pulse fires (1 s at 200 MHz); must be >= 2.
- KEY_ACTIVE_LOW, 1, 1 = key_in reads 0 when pressed; 0 = key_in reads 1 when pressed.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  1  raw asynchronous button pin.
- key_state  output  1  debounced level; 1 = pressed.
- press_pulse  output  1  one-cycle pulse on an accepted press.
- release_pulse  output  1  one-cycle pulse on an accepted release.
- long_pulse  output  1  one-cycle pulse when a press has been held for LONG_CYCLES.
- press_count  output  8  number of accepted presses, wraps 255->0.

Behaviour:
- Interface: one clock, sys_clk; reset rst is synchronous and active-high.
- Input path: 2-FF synchronizer on key_in, then polarity normalisation to key_act (1 = pressed). Synchronizer FFs reset to the inactive pin level.
- Reset values: all outputs 0, state RELEASED, counters 0.
- State machine: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
  - RELEASED: key_act=1 -> PRESS_CHK, deb_cnt=0.
  - PRESS_CHK: key_act=0 -> RELEASED (bounce, no pulse). Otherwise deb_cnt++. When deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED; press_pulse=1 for that transition cycle; key_state=1; press_count++; hold_cnt=0.
  - PRESSED: key_act=0 -> RELEASE_CHK, deb_cnt=0. Otherwise hold_cnt increments and saturates at LONG_CYCLES-1.
  - RELEASE_CHK: key_act=1 -> PRESSED (no pulse, hold_cnt frozen, not cleared). When key_act=0 for DEBOUNCE_CYCLES -> RELEASED; release_pulse=1; key_state=0.
- All outputs are registered.
- Latency: press_pulse asserts exactly DEBOUNCE_CYCLES+3 cycles after key_in is first sampled at the pressed level, given a clean edge. Release latency is identical.
- Counter widths: $clog2 of the respective parameter. deb_cnt never exceeds DEBOUNCE_CYCLES-1. press_count wraps modulo 256.
- Events are exclusive: press_pulse, release_pulse and long_pulse never assert in the same cycle.
- Reset mid-operation: returns to RELEASED immediately with no pulses. A key still held when rst falls is detected as a new press after full debounce.

Optional Feature:
- KEY_LONG_PRESS_EN
  - Defined: hold_cnt logic present. long_pulse fires once, in the cycle hold_cnt reaches LONG_CYCLES-1 while in PRESSED. It does not refire until a new accepted press.
  - Undefined: hold_cnt is removed and long_pulse is tied to 0. LONG_CYCLES is ignored.

Decomposition:
- Package key_pkg holds the state enum (2-bit encoding RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3) and the default cycle constants for 200 MHz.
- Sub-module sync_2ff is a 1-bit, two-stage synchronizer with reset value as a parameter, reusable for other pin inputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, LONG_CYCLES=32, KEY_ACTIVE_LOW=1.
- Clean press: key_in 1->0 held 40 cycles -> press_pulse high exactly 11 cycles after the edge for 1 cycle; key_state=1; press_count=1.
- Bounce: key_in toggles every 3 cycles for 30 cycles, then stays 1 -> no press_pulse; key_state stays 0; press_count=0.
- Release with bounce: from PRESSED, key_in goes 0->1 with a 4-cycle glitch back to 0, then stays 1 -> exactly one release_pulse, 11 cycles after the final stable edge; no second press_pulse.
- Long press (KEY_LONG_PRESS_EN defined): hold for 100 cycles -> exactly one long_pulse, 32 cycles after press_pulse. With the macro undefined, long_pulse stays 0.
- Wrap: 256 clean press/release pairs -> press_count returns to 0 after the 256th press_pulse.
- Reset mid-press: assert rst for 1 cycle during PRESS_CHK while the key is held -> all outputs 0 next cycle. press_pulse arrives 11 cycles after rst deasserts.
